uart_rx_param: RTL and testbench

//  Parametrised UART receiver; successor to the fixed 1-clock-per-bit receiver.

---
 rtl/uart_rx_param.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_param
//  Description : Oversampling UART receiver with configurable frame format and
//                a valid/ready holding register. Optional parity checking is
//                enabled by defining UART_RX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int              c_CW        = $clog2(CLKS_PER_BIT);
  localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0] c_CNT_HALF  = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
  localparam logic [3:0]      c_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      c_STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [c_CW-1:0]      r_cnt;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop_bad;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_fe;
  logic                 r_ov;

  logic w_rxd_s;
  logic w_tick;
  logic w_hs;
  logic w_last_stop;
  logic w_stop_bad;
  logic w_good;

  assign w_rxd_s     = r_sync2;
  assign w_tick      = (r_cnt == c_CNT_LAST);
  assign w_hs        = r_valid & rx_ready;
  assign w_last_stop = (r_state == S_STOP) && w_tick && (r_bit == c_STOP_LAST);
  // Stop verdict includes the sample being taken this cycle.
  assign w_stop_bad  = r_stop_bad | ~w_rxd_s;

`ifdef UART_RX_PARITY_EN
  localparam logic c_PAR_ODD = (PARITY_ODD != 0);
  logic r_par_bad;
  logic r_pe;
  assign w_good     = w_last_stop & ~w_stop_bad & ~r_par_bad;
  assign parity_err = r_pe;
`else
  logic w_unused_par;
  assign w_unused_par = (PARITY_ODD != 0);
  assign w_good       = w_last_stop & ~w_stop_bad;
  assign parity_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_stop_bad <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_fe       <= 1'b0;
      r_ov       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= 1'b0;
      r_pe       <= 1'b0;
`endif
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_fe    <= 1'b0;
      r_ov    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pe    <= 1'b0;
`endif

      case (r_state)
        S_IDLE: begin
          r_cnt      <= '0;
          r_bit      <= '0;
          r_stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
          r_par_bad  <= 1'b0;
`endif
          if (!w_rxd_s) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == c_CNT_HALF) begin
            r_cnt   <= '0;
            r_state <= w_rxd_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
            if (r_bit == c_DATA_LAST) begin
              r_bit <= '0;
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_cnt     <= '0;
            r_par_bad <= (w_rxd_s != ((^r_shift) ^ c_PAR_ODD));
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            r_cnt      <= '0;
            r_stop_bad <= w_stop_bad;
            if (r_bit == c_STOP_LAST) begin
              r_bit   <= '0;
              r_fe    <= w_stop_bad;
`ifdef UART_RX_PARITY_EN
              r_pe    <= r_par_bad;
`endif
              r_state <= w_stop_bad ? S_WAIT_IDLE : S_IDLE;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        S_WAIT_IDLE: begin
          if (w_rxd_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // A handshake in the load cycle frees the slot for the new byte.
      if (w_good) begin
        if (!r_valid || w_hs) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ov <= 1'b1;
        end
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign rx_busy   = (r_state != S_IDLE);
  assign frame_err = r_fe;
  assign overrun   = r_ov;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_param
//  Description : Directed bench for uart_rx_param at 4 clocks per bit, 8N1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

  localparam int CPB = 4;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       rxd      = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  uart_rx_param #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .STOP_BITS   (1),
    .PARITY_ODD  (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int   fe_cnt = 0;
  int   pe_cnt = 0;
  int   ov_cnt = 0;
  int   long_cnt = 0;
  logic fe_q = 1'b0;
  logic pe_q = 1'b0;
  logic ov_q = 1'b0;

  // Pulse counters; a flag high on two consecutive cycles counts as "long".
  always @(posedge clk) begin
    if (frame_err)  fe_cnt <= fe_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (overrun)    ov_cnt <= ov_cnt + 1;
    if ((frame_err && fe_q) || (parity_err && pe_q) || (overrun && ov_q))
      long_cnt <= long_cnt + 1;
    fe_q <= frame_err;
    pe_q <= parity_err;
    ov_q <= overrun;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int fe0, pe0, ov0, long0;

`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    fe0   = fe_cnt;
    pe0   = pe_cnt;
    ov0   = ov_cnt;
    long0 = long_cnt;
  endtask

  task automatic check_flags(input string tag, input int fe_exp, input int ov_exp, input int pe_exp);
    check({tag, "_frame_err"},  fe_cnt - fe0,   fe_exp);
    check({tag, "_overrun"},    ov_cnt - ov0,   ov_exp);
    check({tag, "_parity_err"}, pe_cnt - pe0,   pe_exp);
    check({tag, "_pulse_len"},  long_cnt - long0, 0);
  endtask

  // Called at a negedge; returns at the negedge that ends the last stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic handshake();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  logic busy_seen;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid",  rx_valid,   0);
    check("rst_data",   rx_data,    0);
    check("rst_busy",   rx_busy,    0);
    check("rst_fe",     frame_err,  0);
    check("rst_ov",     overrun,    0);
    check("rst_pe",     parity_err, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Good frame, consumer not ready.
    snap();
    send_frame(8'h55, 1'b1);
    repeat (3) @(negedge clk);
    check("t1_data",  rx_data,  8'h55);
    check("t1_valid", rx_valid, 1);
    check("t1_busy",  rx_busy,  0);
    check_flags("t1", 0, 0, 0);
    repeat (10) @(negedge clk);
    check("t1_hold_data",  rx_data,  8'h55);
    check("t1_hold_valid", rx_valid, 1);
    handshake();
    check("t1_hs_valid", rx_valid, 0);
    check("t1_hs_data",  rx_data,  8'h55);

    // One-clock glitch on the line.
    snap();
    busy_seen = 1'b0;
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    check("t2_busy_seen", busy_seen, 1);
    check("t2_busy",      rx_busy,   0);
    check("t2_valid",     rx_valid,  0);
    check_flags("t2", 0, 0, 0);

    // Bad stop bit followed by a held break.
    snap();
    send_frame(8'hA3, 1'b0);
    repeat (20) @(negedge clk);
    check("t3_valid", rx_valid, 0);
    check("t3_busy",  rx_busy,  1);
    check_flags("t3", 1, 0, 0);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("t3_busy_release", rx_busy, 0);

    // Overrun: second byte dropped while the first is unread.
    snap();
    send_frame(8'h11, 1'b1);
    repeat (3) @(negedge clk);
    check("t4a_data", rx_data, 8'h11);
    send_frame(8'h22, 1'b1);
    repeat (3) @(negedge clk);
    check("t4a_keep_data", rx_data,  8'h11);
    check("t4a_valid",     rx_valid, 1);
    check_flags("t4a", 0, 1, 0);
    handshake();

    // Handshake on the exact load cycle of the second byte.
    send_frame(8'h11, 1'b1);
    repeat (3) @(negedge clk);
    snap();
    send_frame(8'h22, 1'b1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("t4b_data",  rx_data,  8'h22);
    check("t4b_valid", rx_valid, 1);
    check_flags("t4b", 0, 0, 0);

    // Reset in the middle of data bit 4 of 0xFF (0x22 still held).
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check("t6_busy_pre", rx_busy, 1);
    reset = 1'b0;
    #1;
    check("t6_busy",  rx_busy,   0);
    check("t6_valid", rx_valid,  0);
    check("t6_data",  rx_data,   0);
    check("t6_fe",    frame_err, 0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    snap();
    send_frame(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    check("t6_next_data",  rx_data,  8'h3C);
    check("t6_next_valid", rx_valid, 1);
    check("t6_next_busy",  rx_busy,  0);
    check_flags("t6", 0, 0, 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    handshake();
    snap();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    repeat (3) @(negedge clk);
    check("t5_bad_valid", rx_valid, 0);
    check_flags("t5_bad", 0, 0, 1);
    snap();
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    repeat (3) @(negedge clk);
    check("t5_good_data",  rx_data,  8'h07);
    check("t5_good_valid", rx_valid, 1);
    check_flags("t5_good", 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
